// File: rtl/multi_channel_period_meter_pkg.sv
// Shared types and helpers for the multi-channel period meter.
package multi_channel_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DONE
    } chan_state_t;

    // All-ones value of a counter that is `bits` wide (up to 32 bits).
    function automatic logic [31:0] sat_max(input int unsigned bits);
        return (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    endfunction

endpackage

// File: rtl/period_channel.sv
// One measurement channel: input synchroniser, rising/falling edge detection,
// per-channel FSM and saturating high/low accumulators averaged over 2**AVG_LOG2 periods.
module period_channel
    import multi_channel_period_meter_pkg::*;
#(
    parameter int COUNTER_BITS = 15,
    parameter int AVG_LOG2     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_freq,
    input  logic                    i_start,
    input  logic                    i_timeout,
    input  logic                    i_ack,
    output logic                    o_done,
    output logic                    o_timed_out,
    output logic [COUNTER_BITS-1:0] o_high,
    output logic [COUNTER_BITS-1:0] o_low,
    output logic [COUNTER_BITS-1:0] o_period
);

    localparam int AW = COUNTER_BITS + AVG_LOG2;
    localparam logic [COUNTER_BITS-1:0] CNT_MAX = COUNTER_BITS'(sat_max(COUNTER_BITS));
    localparam logic [AVG_LOG2:0] LAST_EDGE = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_prev;
    chan_state_t             r_state;
    chan_state_t             w_state_next;
    logic [AW-1:0]           r_acc_high;
    logic [AW-1:0]           r_acc_low;
    logic [AVG_LOG2:0]       r_edge_cnt;
    logic [COUNTER_BITS-1:0] r_high;
    logic [COUNTER_BITS-1:0] r_low;
    logic [COUNTER_BITS-1:0] r_period;
    logic                    r_timed_out;

    logic                    w_rise;
    logic                    w_last_rise;
    logic                    w_enter_measure;
    logic                    w_finish_meas;
    logic                    w_finish_timeout;
    logic [COUNTER_BITS-1:0] w_avg_high;
    logic [COUNTER_BITS-1:0] w_avg_low;
    logic [COUNTER_BITS:0]   w_sum;
    logic [COUNTER_BITS-1:0] w_period;

    assign w_rise      = r_sync2 & ~r_prev;
    assign w_last_rise = w_rise & (r_edge_cnt == LAST_EDGE);
    assign w_avg_high  = r_acc_high[AW-1:AVG_LOG2];
    assign w_avg_low   = r_acc_low[AW-1:AVG_LOG2];
    assign w_sum       = {1'b0, w_avg_high} + {1'b0, w_avg_low};
    assign w_period    = w_sum[COUNTER_BITS] ? CNT_MAX : w_sum[COUNTER_BITS-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Timeout wins over a coincident final rising edge.
    always_comb begin
        w_state_next     = r_state;
        w_enter_measure  = 1'b0;
        w_finish_meas    = 1'b0;
        w_finish_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_next = ST_ARM;
            end
            ST_ARM: begin
                if (i_timeout) begin
                    w_state_next     = ST_DONE;
                    w_finish_timeout = 1'b1;
                end else if (w_rise) begin
                    w_state_next    = ST_MEASURE;
                    w_enter_measure = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (i_timeout) begin
                    w_state_next     = ST_DONE;
                    w_finish_timeout = 1'b1;
                end else if (w_last_rise) begin
                    w_state_next  = ST_DONE;
                    w_finish_meas = 1'b1;
                end
            end
            ST_DONE: begin
                if (i_ack) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_prev      <= 1'b0;
            r_acc_high  <= '0;
            r_acc_low   <= '0;
            r_edge_cnt  <= '0;
            r_high      <= '0;
            r_low       <= '0;
            r_period    <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_sync1 <= i_freq;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // The rising-edge cycle itself is the first high cycle of the window.
            if (w_enter_measure) begin
                r_acc_high <= AW'(1);
                r_acc_low  <= '0;
                r_edge_cnt <= '0;
            end else if (r_state == ST_MEASURE) begin
                if (w_rise) r_edge_cnt <= r_edge_cnt + (AVG_LOG2 + 1)'(1);
                if (r_sync2) begin
                    if (!(&r_acc_high)) r_acc_high <= r_acc_high + AW'(1);
                end else begin
                    if (!(&r_acc_low)) r_acc_low <= r_acc_low + AW'(1);
                end
            end
            if (w_finish_meas) begin
                r_high      <= w_avg_high;
                r_low       <= w_avg_low;
                r_period    <= w_period;
                r_timed_out <= 1'b0;
            end else if (w_finish_timeout) begin
                r_high      <= CNT_MAX;
                r_low       <= CNT_MAX;
                r_period    <= CNT_MAX;
                r_timed_out <= 1'b1;
            end
        end
    end

    assign o_done      = (r_state == ST_DONE);
    assign o_timed_out = r_timed_out;
    assign o_high      = r_high;
    assign o_low       = r_low;
    assign o_period    = r_period;

endmodule

// File: rtl/multi_channel_period_meter.sv
// Multi-channel period meter: START arms every channel, a shared timer bounds the
// measurement, and results are handed out in channel order over a valid/ready port.
module multi_channel_period_meter
    import multi_channel_period_meter_pkg::*;
#(
    parameter int CHANNELS       = 8,
    parameter int COUNTER_BITS   = 15,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 2**COUNTER_BITS - 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [CHANNELS-1:0]         FREQ_IN,
    input  logic                        START,
    output logic                        BUSY,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic [$clog2(CHANNELS)-1:0] OUT_CHANNEL,
    output logic [COUNTER_BITS-1:0]     OUT_HIGH,
    output logic [COUNTER_BITS-1:0]     OUT_LOW,
    output logic [COUNTER_BITS-1:0]     OUT_PERIOD,
    output logic                        OUT_TIMEOUT
);

    localparam int CW = $clog2(CHANNELS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          r_busy;
    logic [CW-1:0] r_ptr;
    logic [TW-1:0] r_timer;

    logic w_start_accept;
    logic w_timeout;
    logic w_accept;
    logic w_last_accept;

    logic [CHANNELS-1:0]     w_done;
    logic [CHANNELS-1:0]     w_timed_out;
    logic [CHANNELS-1:0]     w_ack;
    logic [COUNTER_BITS-1:0] w_high   [CHANNELS];
    logic [COUNTER_BITS-1:0] w_low    [CHANNELS];
    logic [COUNTER_BITS-1:0] w_period [CHANNELS];

    assign w_start_accept = START & ~r_busy;
    assign w_timeout      = r_busy & (r_timer == TW'(TIMEOUT_CYCLES));
    assign w_accept       = OUT_VALID & OUT_READY;
    assign w_last_accept  = w_accept & (r_ptr == CW'(CHANNELS - 1));

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign w_ack[gi] = w_accept & (r_ptr == CW'(gi));

            period_channel #(
                .COUNTER_BITS (COUNTER_BITS),
                .AVG_LOG2     (AVG_LOG2)
            ) u_chan (
                .clk         (CLK),
                .rst         (RST),
                .i_freq      (FREQ_IN[gi]),
                .i_start     (w_start_accept),
                .i_timeout   (w_timeout),
                .i_ack       (w_ack[gi]),
                .o_done      (w_done[gi]),
                .o_timed_out (w_timed_out[gi]),
                .o_high      (w_high[gi]),
                .o_low       (w_low[gi]),
                .o_period    (w_period[gi])
            );
        end
    endgenerate

    // Timer reads 1 in the first busy cycle, so it equals TIMEOUT_CYCLES exactly
    // TIMEOUT_CYCLES-1 edges after START; it then holds there.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_timer <= '0;
        end else begin
            if (w_start_accept) begin
                r_busy  <= 1'b1;
                r_timer <= TW'(1);
            end else if (r_busy && !w_timeout) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_last_accept) begin
                r_busy <= 1'b0;
                r_ptr  <= '0;
            end else if (w_accept) begin
                r_ptr <= r_ptr + CW'(1);
            end
        end
    end

    assign BUSY        = r_busy;
    assign OUT_VALID   = r_busy & w_done[r_ptr];
    assign OUT_CHANNEL = r_ptr;
    assign OUT_HIGH    = OUT_VALID ? w_high[r_ptr] : '0;
    assign OUT_LOW     = OUT_VALID ? w_low[r_ptr] : '0;
    assign OUT_PERIOD  = OUT_VALID ? w_period[r_ptr] : '0;
    assign OUT_TIMEOUT = OUT_VALID & w_timed_out[r_ptr];

endmodule
